// File: rtl/instr_encoder_pkg.sv
// Shared encoder constants: format codes, opcodes and the range helper.
// Imported by the pack sub-module and the streaming top.
package instr_encoder_pkg;

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_LI  = 3'd6;
   localparam logic [2:0] FMT_ILL = 3'd7;

   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_OPIMM = 7'h13;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [4:0]  rd;
      logic [11:0] lo;
   } liTail_t;

   function automatic logic fitsSigned(input logic [31:0] v,
                                       input int bits);
      int lim;
      lim = 1 << (bits - 1);
      return ($signed(v) >= -lim) && ($signed(v) < lim);
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request and instruction-stream handshake bundle of the encoder.
// master drives requests and output ready; slave is the encoder.
interface instr_encoder_if;

   logic        i_ReqValid;
   logic        o_ReqReady;
   logic [2:0]  i_Format;
   logic [6:0]  i_Opcode;
   logic [4:0]  i_Rd;
   logic [4:0]  i_Rs1;
   logic [4:0]  i_Rs2;
   logic [2:0]  i_Funct3;
   logic [6:0]  i_Funct7;
   logic [31:0] i_Imm;
   logic        o_InstrValid;
   logic        i_InstrReady;
   logic [31:0] o_Instruction;
   logic        o_Last;
   logic        o_ImmError;

   modport master (
      output i_ReqValid, i_Format, i_Opcode,
      output i_Rd, i_Rs1, i_Rs2,
      output i_Funct3, i_Funct7, i_Imm,
      output i_InstrReady,
      input  o_ReqReady, o_InstrValid,
      input  o_Instruction, o_Last, o_ImmError
   );

   modport slave (
      input  i_ReqValid, i_Format, i_Opcode,
      input  i_Rd, i_Rs1, i_Rs2,
      input  i_Funct3, i_Funct7, i_Imm,
      input  i_InstrReady,
      output o_ReqReady, o_InstrValid,
      output o_Instruction, o_Last, o_ImmError
   );

endinterface

// File: rtl/instr_pack.sv
// Combinational RV32I packer: scatters immediate bits per format
// and flags immediates that the format cannot represent.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        err
);

   always_comb begin
      word = INSTR_NOP;
      err  = 1'b0;
      unique case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word = {imm[11:0], rs1, funct3, rd, opcode};
            err  = !fitsSigned(imm, 12);
         end
         FMT_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            err  = !fitsSigned(imm, 12);
         end
         FMT_B: begin
            word = {imm[12], imm[10:5], rs2, rs1, funct3,
                    imm[4:1], imm[11], opcode};
            err  = !fitsSigned(imm, 13) || imm[0];
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
            err  = |imm[11:0];
         end
         FMT_J: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            err  = !fitsSigned(imm, 21) || imm[0];
         end
         default: begin
            word = INSTR_NOP;
            err  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder with LI expansion into LUI/ADDI.
// One packer serves both the request word and the trailing ADDI.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int WORD_SIZE = 32
) (
   input logic            i_clk,
   input logic            i_rst_n,
   instr_encoder_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] EMIT1 = 2'd1;
   localparam logic [1:0] EMIT2 = 2'd2;

   logic [1:0]           state;
   liTail_t              tail;
   logic                 validQ;
   logic                 lastQ;
   logic                 errQ;
   logic [WORD_SIZE-1:0] instrQ;

   logic [2:0]  pFmt;
   logic [6:0]  pOp;
   logic [4:0]  pRd;
   logic [4:0]  pRs1;
   logic [4:0]  pRs2;
   logic [2:0]  pF3;
   logic [6:0]  pF7;
   logic [31:0] pImm;
   logic [31:0] pWord;
   logic        pErr;
   logic        firstLast;
   logic [31:0] liHi;
   logic        fire;

   assign liHi = bus.i_Imm + 32'h0000_0800;
   assign fire = validQ && bus.i_InstrReady;

   // Outside IDLE the packer only ever builds the LI tail ADDI.
   always_comb begin
      pFmt      = bus.i_Format;
      pOp       = bus.i_Opcode;
      pRd       = bus.i_Rd;
      pRs1      = bus.i_Rs1;
      pRs2      = bus.i_Rs2;
      pF3       = bus.i_Funct3;
      pF7       = bus.i_Funct7;
      pImm      = bus.i_Imm;
      firstLast = 1'b1;
      if (state != IDLE) begin
         pFmt = FMT_I;
         pOp  = OPC_OPIMM;
         pRd  = tail.rd;
         pRs1 = tail.rd;
         pF3  = 3'd0;
         pImm = {{20{tail.lo[11]}}, tail.lo};
      end else if (bus.i_Format == FMT_LI) begin
         if (fitsSigned(bus.i_Imm, 12)) begin
            pFmt = FMT_I;
            pOp  = OPC_OPIMM;
            pRs1 = 5'd0;
            pF3  = 3'd0;
         end else if (bus.i_Imm[11:0] == 12'd0) begin
            pFmt = FMT_U;
            pOp  = OPC_LUI;
         end else begin
            pFmt      = FMT_U;
            pOp       = OPC_LUI;
            pImm      = {liHi[31:12], 12'd0};
            firstLast = 1'b0;
         end
      end
   end

   instr_pack u_pack (
      .fmt    (pFmt),
      .opcode (pOp),
      .rd     (pRd),
      .rs1    (pRs1),
      .rs2    (pRs2),
      .funct3 (pF3),
      .funct7 (pF7),
      .imm    (pImm),
      .word   (pWord),
      .err    (pErr)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         tail   <= '0;
         validQ <= 1'b0;
         lastQ  <= 1'b0;
         errQ   <= 1'b0;
         instrQ <= '0;
      end else begin
         unique case (state)
            IDLE: if (bus.i_ReqValid) begin
               state  <= EMIT1;
               validQ <= 1'b1;
               instrQ <= pWord;
               lastQ  <= firstLast;
               errQ   <= pErr;
               tail   <= '{rd: bus.i_Rd, lo: bus.i_Imm[11:0]};
            end
            EMIT1: if (fire) begin
               if (lastQ) begin
                  state  <= IDLE;
                  validQ <= 1'b0;
               end else begin
                  state  <= EMIT2;
                  instrQ <= pWord;
                  lastQ  <= 1'b1;
                  errQ   <= pErr;
               end
            end
            EMIT2: if (fire) begin
               state  <= IDLE;
               validQ <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               validQ <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ReqReady    = (state == IDLE);
   assign bus.o_InstrValid  = validQ;
   assign bus.o_Instruction = instrQ;
   assign bus.o_Last        = lastQ;
   assign bus.o_ImmError    = errQ;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: formats, LI, backpressure,
// back-to-back streaming and reset in the middle of an LI pair.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   typedef struct packed {
      logic [2:0]  f;
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
   } req_t;

   typedef struct packed {
      logic        v;
      logic [31:0] w;
      logic        l;
      logic        e;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_encoder_if bus ();

   instr_encoder #(.WORD_SIZE(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic req_t mk(input logic [2:0] f,
                               input logic [6:0] op,
                               input logic [4:0] rd,
                               input logic [4:0] rs1,
                               input logic [4:0] rs2,
                               input logic [2:0] f3,
                               input logic [6:0] f7,
                               input logic [31:0] imm);
      return '{f: f, op: op, rd: rd, rs1: rs1, rs2: rs2,
               f3: f3, f7: f7, imm: imm};
   endfunction

   function automatic exp_t ex(input logic [31:0] w,
                               input logic l, input logic e);
      return '{v: 1'b1, w: w, l: l, e: e};
   endfunction

   task automatic idle_inputs();
      bus.i_ReqValid   = 1'b0;
      bus.i_Format     = '0;
      bus.i_Opcode     = '0;
      bus.i_Rd         = '0;
      bus.i_Rs1        = '0;
      bus.i_Rs2        = '0;
      bus.i_Funct3     = '0;
      bus.i_Funct7     = '0;
      bus.i_Imm        = '0;
      bus.i_InstrReady = 1'b0;
   endtask

   task automatic send(input req_t r, output bit acc);
      @(negedge clk);
      bus.i_Format   = r.f;
      bus.i_Opcode   = r.op;
      bus.i_Rd       = r.rd;
      bus.i_Rs1      = r.rs1;
      bus.i_Rs2      = r.rs2;
      bus.i_Funct3   = r.f3;
      bus.i_Funct7   = r.f7;
      bus.i_Imm      = r.imm;
      bus.i_ReqValid = 1'b1;
      acc = bus.o_ReqReady;
      @(posedge clk);
      @(negedge clk);
      bus.i_ReqValid = 1'b0;
   endtask

   // Waits (bounded) for a word, holds it for 'hold' cycles, consumes it.
   task automatic collect(input int hold, output exp_t got,
                          output int waited, output int unstable,
                          output int rqHigh);
      waited = 0;
      while (bus.o_InstrValid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      got = '{v: bus.o_InstrValid, w: bus.o_Instruction,
              l: bus.o_Last, e: bus.o_ImmError};
      unstable = 0;
      rqHigh = 0;
      repeat (hold) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.o_InstrValid !== 1'b1 ||
             bus.o_Instruction !== got.w ||
             bus.o_Last !== got.l || bus.o_ImmError !== got.e)
            unstable++;
         if (bus.o_ReqReady !== 1'b0) rqHigh++;
      end
      bus.i_InstrReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.i_InstrReady = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++;
      if (bus.o_InstrValid !== 1'b0 || bus.o_Instruction !== 32'd0 ||
          bus.o_Last !== 1'b0 || bus.o_ImmError !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b w=%08h l=%0b e=%0b want 0",
                  bus.o_InstrValid, bus.o_Instruction,
                  bus.o_Last, bus.o_ImmError);
      end
      checks++;
      if (bus.o_ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got %0b want 1", bus.o_ReqReady);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_addi();
      bit   acc;
      exp_t got, e;
      int   w, u, r;
      send(mk(FMT_I, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0,
              32'hFFFF_FFFF), acc);
      sb.push_back(ex(32'hFFF3_0293, 1'b1, 1'b0));
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL addi_accept got %0b want 1", acc);
      end
      checks++;
      if (bus.o_InstrValid !== 1'b1) begin
         errors++;
         $display("FAIL addi_latency got valid=%0b want 1",
                  bus.o_InstrValid);
      end
      collect(0, got, w, u, r);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL addi_word got %09h want %09h", got, e);
      end
      checks++;
      if (bus.o_InstrValid !== 1'b0 || bus.o_ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL addi_idle got v=%0b rdy=%0b want v=0 rdy=1",
                  bus.o_InstrValid, bus.o_ReqReady);
      end
   endtask

   task automatic test_formats();
      req_t rq[15];
      exp_t xp[15];
      bit   acc;
      exp_t got, e;
      int   w, u, r;
      rq[0]  = mk(FMT_R, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
      xp[0]  = ex(32'h4020_81B3, 1'b1, 1'b0);
      rq[1]  = mk(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
      xp[1]  = ex(32'h8000_0013, 1'b1, 1'b1);
      rq[2]  = mk(FMT_I, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
      xp[2]  = ex(32'h8000_0013, 1'b1, 1'b0);
      rq[3]  = mk(FMT_S, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC);
      xp[3]  = ex(32'hFE20_AE23, 1'b1, 1'b0);
      rq[4]  = mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
      xp[4]  = ex(32'h0020_8463, 1'b1, 1'b0);
      rq[5]  = mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
      xp[5]  = ex(32'h0020_8363, 1'b1, 1'b1);
      rq[6]  = mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096);
      xp[6]  = ex(32'h8020_8063, 1'b1, 1'b1);
      rq[7]  = mk(FMT_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_F000);
      xp[7]  = ex(32'h8020_8063, 1'b1, 1'b0);
      rq[8]  = mk(FMT_U, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
      xp[8]  = ex(32'h0000_11B7, 1'b1, 1'b1);
      rq[9]  = mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
      xp[9]  = ex(32'h0010_00EF, 1'b1, 1'b0);
      rq[10] = mk(FMT_J, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
      xp[10] = ex(32'h8000_00EF, 1'b1, 1'b1);
      rq[11] = mk(FMT_ILL, 7'h33, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
      xp[11] = ex(32'h0000_0013, 1'b1, 1'b1);
      rq[12] = mk(FMT_LI, 7'h7F, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCD_E000);
      xp[12] = ex(32'hABCD_E137, 1'b1, 1'b0);
      rq[13] = mk(FMT_LI, 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd100);
      xp[13] = ex(32'h0640_0093, 1'b1, 1'b0);
      rq[14] = mk(FMT_LI, 7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
      xp[14] = ex(32'h8000_0093, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) begin
         send(rq[i], acc);
         sb.push_back(xp[i]);
         collect(0, got, w, u, r);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL format_%0d got %09h want %09h", i, got, e);
         end
      end
   endtask

   task automatic test_li_two();
      bit   acc;
      exp_t got, e;
      int   w, u, r;
      send(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,
              32'h1234_5FFF), acc);
      sb.push_back(ex(32'h1234_6537, 1'b0, 1'b0));
      sb.push_back(ex(32'hFFF5_0513, 1'b1, 1'b0));
      for (int k = 0; k < 2; k++) begin
         collect(0, got, w, u, r);
         e = sb.pop_front();
         checks++;
         if (got !== e || w != 0) begin
            errors++;
            $display("FAIL li_pair_%0d got %09h wait=%0d want %09h wait=0",
                     k, got, w, e);
         end
      end
      send(mk(FMT_LI, 7'h00, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0,
              32'h0000_0800), acc);
      sb.push_back(ex(32'h0000_12B7, 1'b0, 1'b0));
      sb.push_back(ex(32'h8002_8293, 1'b1, 1'b0));
      for (int k = 0; k < 2; k++) begin
         collect(0, got, w, u, r);
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL li_carry_%0d got %09h want %09h", k, got, e);
         end
      end
   endtask

   task automatic test_backpressure();
      bit   acc;
      exp_t got, e;
      int   w, u, r;
      send(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,
              32'h1234_5FFF), acc);
      sb.push_back(ex(32'h1234_6537, 1'b0, 1'b0));
      sb.push_back(ex(32'hFFF5_0513, 1'b1, 1'b0));
      for (int k = 0; k < 2; k++) begin
         collect(3, got, w, u, r);
         e = sb.pop_front();
         checks++;
         if (got !== e || u != 0 || r != 0) begin
            errors++;
            $display("FAIL bp_word_%0d got %09h unstable=%0d rdy=%0d want %09h 0 0",
                     k, got, u, r, e);
         end
      end
      checks++;
      if (bus.o_InstrValid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL bp_no_dup got v=%0b left=%0d want v=0 left=0",
                  bus.o_InstrValid, sb.size());
      end
   endtask

   task automatic test_back_to_back();
      bit   acc;
      exp_t got, e;
      bus.i_InstrReady = 1'b1;
      send(mk(FMT_I, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), acc);
      sb.push_back(ex(32'h0050_0393, 1'b1, 1'b0));
      send(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,
              32'h1234_5FFF), acc);
      checks++;
      if (acc !== 1'b1) begin
         errors++;
         $display("FAIL b2b_accept got %0b want 1", acc);
      end
      sb.push_back(ex(32'h1234_6537, 1'b0, 1'b0));
      sb.push_back(ex(32'hFFF5_0513, 1'b1, 1'b0));
      e = sb.pop_front();
      for (int k = 0; k < 2; k++) begin
         got = '{v: bus.o_InstrValid, w: bus.o_Instruction,
                 l: bus.o_Last, e: bus.o_ImmError};
         e = sb.pop_front();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL b2b_li_%0d got %09h want %09h", k, got, e);
         end
         @(negedge clk);
      end
      checks++;
      if (bus.o_InstrValid !== 1'b0 || bus.o_ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drain got v=%0b rdy=%0b want v=0 rdy=1",
                  bus.o_InstrValid, bus.o_ReqReady);
      end
      bus.i_InstrReady = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit   acc;
      exp_t got, e;
      int   w, u, r;
      send(mk(FMT_LI, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,
              32'h1234_5FFF), acc);
      sb.push_back(ex(32'h1234_6537, 1'b0, 1'b0));
      sb.push_back(ex(32'hFFF5_0513, 1'b1, 1'b0));
      collect(0, got, w, u, r);
      e = sb.pop_front();
      checks++;
      if (got !== e || bus.o_InstrValid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_first got %09h v2=%0b want %09h v2=1",
                  got, bus.o_InstrValid, e);
      end
      #2 rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      checks++;
      if (bus.o_InstrValid !== 1'b0 || bus.o_Instruction !== 32'd0 ||
          bus.o_Last !== 1'b0 || bus.o_ImmError !== 1'b0 ||
          bus.o_ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_async got v=%0b w=%08h l=%0b e=%0b rdy=%0b want 0 0 0 0 1",
                  bus.o_InstrValid, bus.o_Instruction, bus.o_Last,
                  bus.o_ImmError, bus.o_ReqReady);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.o_InstrValid !== 1'b0 || bus.o_ReqReady !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_release got v=%0b rdy=%0b want v=0 rdy=1",
                  bus.o_InstrValid, bus.o_ReqReady);
      end
      send(mk(FMT_I, 7'h13, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), acc);
      sb.push_back(ex(32'h0050_0393, 1'b1, 1'b0));
      collect(0, got, w, u, r);
      e = sb.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL rst_mid_after got %09h want %09h", got, e);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d want 0", sb.size());
      end
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_addi();
      test_formats();
      test_li_two();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
